icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache between the core's fetch stage and the bus arbiter's instruction port (irequest/iaddr/idata/idone).
- Serves 64-bit aligned fetch words from 64-byte lines.
- On a miss it requests the whole line from the arbiter, fills the line, then returns the requested word.
- Includes a full-cache flush and saturating hit and miss counters.

---
 rtl/icache_direct.sv | 135 +++++++++++++
 tb/tb_icache_direct.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
`default_nettype none
// ---------------------------------------------------------------------------
// icache_direct : direct-mapped read-only instruction cache, 64-byte lines
// Rev 1.0
// ---------------------------------------------------------------------------
module icache_direct #(
  parameter int NSETS = 64,
  parameter int IDX_W = $clog2(NSETS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_req,
  input  logic [63:0]  fetch_addr,
  output logic         fetch_ack,
  output logic [63:0]  fetch_data,
  input  logic         flush,
  output logic         irequest,
  output logic [63:0]  iaddr,
  input  logic [511:0] idata,
  input  logic         idone,
  output logic [31:0]  perf_hits,
  output logic [31:0]  perf_misses
);

  localparam int TAG_W = 58 - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MISS = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NSETS-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [NSETS];
  logic [511:0]       data_q [NSETS];
  logic               fetch_ack_q, fetch_ack_d;
  logic [63:0]        fetch_data_q, fetch_data_d;
  logic [63:0]        iaddr_q, iaddr_d;
  logic [31:0]        hits_q, hits_d;
  logic [31:0]        misses_q, misses_d;

  logic [2:0]         offset;
  logic [IDX_W-1:0]   index;
  logic [TAG_W-1:0]   tag;
  logic [511:0]       line_rd;
  logic               hit;
  logic               fill_we;
  logic               unused_addr_bits;

  assign offset           = fetch_addr[5:3];
  assign index            = fetch_addr[6 +: IDX_W];
  assign tag              = fetch_addr[63 -: TAG_W];
  assign line_rd          = data_q[index];
  assign hit              = fetch_req && valid_q[index] && (tag_q[index] == tag);
  assign fill_we          = (state_q == S_MISS) && idone;
  assign unused_addr_bits = ^fetch_addr[2:0];

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    fetch_ack_d  = 1'b0;
    fetch_data_d = fetch_data_q;
    iaddr_d      = iaddr_q;
    hits_d       = hits_q;
    misses_d     = misses_q;
    irequest     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The request still asserted during an ack cycle is the one just served.
        if (fetch_req && !fetch_ack_q) begin
          if (hit) begin
            fetch_ack_d  = 1'b1;
            fetch_data_d = line_rd[{offset, 6'b0} +: 64];
            if (hits_q != 32'hFFFF_FFFF) hits_d = hits_q + 32'd1;
          end else begin
            state_d = S_MISS;
            iaddr_d = {fetch_addr[63:6], 6'b0};
            if (misses_q != 32'hFFFF_FFFF) misses_d = misses_q + 32'd1;
          end
        end
      end
      S_MISS: begin
        // Dropped during idone so the arbiter never sees a stale request.
        irequest = !idone;
        if (idone) begin
          valid_d[index] = 1'b1;
          fetch_ack_d    = 1'b1;
          fetch_data_d   = idata[{offset, 6'b0} +: 64];
          state_d        = S_FILL;
        end
      end
      S_FILL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      fetch_ack_q  <= 1'b0;
      fetch_data_q <= 64'd0;
      iaddr_q      <= 64'd0;
      hits_q       <= 32'd0;
      misses_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      fetch_ack_q  <= fetch_ack_d;
      fetch_data_q <= fetch_data_d;
      iaddr_q      <= iaddr_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[index]  <= tag;
      data_q[index] <= idata;
    end
  end

  assign fetch_ack   = fetch_ack_q;
  assign fetch_data  = fetch_data_q;
  assign iaddr       = iaddr_q;
  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_icache_direct : scoreboard bench for icache_direct
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_icache_direct;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         fetch_req = 1'b0;
  logic [63:0]  fetch_addr = 64'd0;
  logic         fetch_ack;
  logic [63:0]  fetch_data;
  logic         flush = 1'b0;
  logic         irequest;
  logic [63:0]  iaddr;
  logic [511:0] idata = '0;
  logic         idone = 1'b0;
  logic [31:0]  perf_hits;
  logic [31:0]  perf_misses;

  int n_checks = 0;
  int n_fail   = 0;
  int acks_seen = 0;
  logic [63:0] exp_q[$];

  icache_direct #(.NSETS(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ack   (fetch_ack),
    .fetch_data  (fetch_data),
    .flush       (flush),
    .irequest    (irequest),
    .iaddr       (iaddr),
    .idata       (idata),
    .idone       (idone),
    .perf_hits   (perf_hits),
    .perf_misses (perf_misses)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Backing-memory model: every word is unique to its byte address.
  function automatic logic [63:0] word_at(input logic [63:0] a);
    return {32'hDEAD_BEEF, a[31:0] ^ 32'h0000_1000};
  endfunction

  function automatic logic [511:0] line_data(input logic [63:0] la);
    logic [511:0] d;
    for (int w = 0; w < 8; w++) d[64*w +: 64] = word_at(la + 64'(8*w));
    return d;
  endfunction

  always @(negedge clk) begin
    if (fetch_ack) begin
      acks_seen++;
      if (exp_q.size() == 0) check("unexpected_ack", {63'd0, fetch_ack}, 64'd0);
      else check("ack_data", fetch_data, exp_q.pop_front());
    end
  end

  task automatic do_fetch(input logic [63:0] addr, input bit miss, input int delay,
                          input logic [63:0] late_addr, input bit fl);
    int start;
    logic [63:0] la;
    la    = {addr[63:6], 6'b0};
    start = acks_seen;
    exp_q.push_back(word_at({late_addr[63:3], 3'b0}));
    fetch_req  = 1'b1;
    fetch_addr = addr;
    if (!miss) flush = fl;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    if (miss) begin
      check("irequest_rise", {63'd0, irequest}, 64'd1);
      check("iaddr", iaddr, la);
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        check("irequest_hold", {63'd0, irequest}, 64'd1);
        check("iaddr_hold", iaddr, la);
      end
      @(posedge clk); #1;
      fetch_addr = late_addr;
      idone      = 1'b1;
      idata      = line_data(la);
      flush      = fl;
      @(negedge clk);
      check("irequest_idone", {63'd0, irequest}, 64'd0);
      @(posedge clk); #1;
      idone = 1'b0;
      flush = 1'b0;
      idata = '0;
      @(negedge clk);
      check("irequest_fill", {63'd0, irequest}, 64'd0);
    end else begin
      check("irequest_hit", {63'd0, irequest}, 64'd0);
    end
    #1;
    check("ack_latency", 64'(acks_seen), 64'(start + 1));
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {63'd0, fetch_ack}, 64'd0);
    check("rst_data", fetch_data, 64'd0);
    check("rst_irequest", {63'd0, irequest}, 64'd0);
    check("rst_iaddr", iaddr, 64'd0);
    check("rst_hits", 64'(perf_hits), 64'd0);
    check("rst_misses", 64'(perf_misses), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    do_fetch(64'h1000, 1'b1, 4, 64'h1010, 1'b0);
    check("misses_1", 64'(perf_misses), 64'd1);
    do_fetch(64'h1018, 1'b0, 0, 64'h1018, 1'b0);
    check("hits_1", 64'(perf_hits), 64'd1);

    // Same index, different tags: each fill evicts the other.
    do_fetch(64'h2000, 1'b1, 2, 64'h2000, 1'b0);
    do_fetch(64'h1008, 1'b1, 1, 64'h1008, 1'b0);
    do_fetch(64'h2008, 1'b1, 0, 64'h2008, 1'b0);
    check("misses_conflict", 64'(perf_misses), 64'd4);
    check("hits_conflict", 64'(perf_hits), 64'd1);

    do_fetch(64'h3040, 1'b1, 200, 64'h3040, 1'b0);
    do_fetch(64'h3048, 1'b0, 0, 64'h3048, 1'b0);

    do_fetch(64'h4000, 1'b1, 3, 64'h4000, 1'b1);
    do_fetch(64'h4000, 1'b1, 1, 64'h4000, 1'b0);
    do_fetch(64'h4010, 1'b0, 0, 64'h4010, 1'b1);
    do_fetch(64'h4010, 1'b1, 0, 64'h4010, 1'b0);
    check("hits_flush", 64'(perf_hits), 64'd3);
    check("misses_flush", 64'(perf_misses), 64'd8);

    // Reset while a miss is outstanding, then a stray idone.
    fetch_req  = 1'b1;
    fetch_addr = 64'h5000;
    @(posedge clk); #1;
    reset     = 1'b0;
    fetch_req = 1'b0;
    @(negedge clk);
    check("pre_rst_irequest", {63'd0, irequest}, 64'd1);
    @(negedge clk);
    check("mid_rst_irequest", {63'd0, irequest}, 64'd0);
    check("mid_rst_misses", 64'(perf_misses), 64'd0);
    check("mid_rst_hits", 64'(perf_hits), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    start = acks_seen;
    idone = 1'b1;
    idata = line_data(64'h5000);
    @(posedge clk); #1;
    idone = 1'b0;
    idata = '0;
    @(negedge clk);
    check("stray_irequest", {63'd0, irequest}, 64'd0);
    @(negedge clk); #1;
    check("stray_no_ack", 64'(acks_seen), 64'(start));
    @(posedge clk); #1;
    do_fetch(64'h5000, 1'b1, 1, 64'h5008, 1'b0);
    check("misses_after_rst", 64'(perf_misses), 64'd1);

    repeat (2) @(posedge clk);
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
